bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Parametrised, iterative binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm. It processes one input bit per clock, so a WIDTH-bit operand of any size costs one set of DIGITS correction cells rather than a triangular combinational array. It sits behind the ALU result register and feeds the seven-segment display path. It uses a start/busy/done handshake and holds its result until the next conversion completes.

## Interface
- WIDTH, 8: binary operand width; valid range 2..32.
- DIGITS, 3: number of BCD output digits; valid range 1..10.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion; sampled only in IDLE or DONE.
- bin  in  WIDTH  operand; captured on the accepting edge only.
- busy  out  1  high while in CONV.
- done  out  1  one-cycle pulse when the result is updated.
- bcd  out  4*DIGITS  result, least-significant digit in bits [3:0].
- overflow  out  1  result does not fit in DIGITS digits; valid with done, held with bcd.
- neg  out  1  sign of the result (see Configuration).

## Operation
- States: IDLE, CONV, DONE. After reset the state is IDLE.
- IDLE or DONE with start=1: capture bin into the shift register, clear the scratch digits, load the bit counter with WIDTH, clear the overflow accumulator, go to CONV.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- CONV, each cycle:
  - For every scratch digit ≥5, add 3.
  - Shift {scratch digits, operand} left by one.
  - If the bit shifted out of the top digit is 1, set the overflow accumulator.
  - Decrement the counter.
- CONV exit: when the counter reaches 0, load the scratch digits into bcd, copy the accumulator into overflow, go to DONE.
- start during CONV is ignored. It is not queued, and bin is not re-sampled.
- Overflow: bcd holds the low DIGITS digits of the true decimal value. For example, WIDTH=8, DIGITS=2, bin=100 gives bcd=0x00 and overflow=1.
- Width rules:
  - The scratch register is 4*DIGITS bits wide and the operand shifter is WIDTH bits wide.
  - Each add-3 operates on 4 bits with no carry out, because a digit ≥5 plus 3 is ≤12.
  - The counter is $clog2(WIDTH+1) bits wide.
- Reset values: busy=0, done=0, bcd=0, overflow=0, neg=0, counter=0, scratch=0, state IDLE.
- rst during CONV: abandon the conversion; no done pulse; outputs take their reset values on the next edge.
- rst has priority over start on the same edge.

## Timing
- Edge 0: start accepted.
- Cycles 1..WIDTH: busy=1.
- Cycle WIDTH+1: done=1 and the new bcd/overflow/neg are visible; busy=0.
- Latency from the accepting edge to done is WIDTH+1 cycles.
- Back-to-back: start held high in the DONE cycle is accepted there, so throughput is one conversion per WIDTH+1 cycles.
- bcd, overflow and neg are registered. They change only on the edge that enters DONE, or on reset.
- done is high for exactly one cycle per accepted conversion.

## Configuration
- BIN2BCD_SIGNED_EN defined:
  - bin is two's complement. On the accepting edge the block captures the magnitude (bin[WIDTH-1] ? -bin : bin) as an unsigned WIDTH-bit value, and the sign bit.
  - neg reflects the captured sign from the DONE edge and holds with bcd.
  - The most negative value converts correctly: -2^(WIDTH-1) gives magnitude 2^(WIDTH-1).
  - Zero always gives neg=0.
- BIN2BCD_SIGNED_EN undefined: bin is unsigned, neg is tied to 0, and no negation logic is built.
- Latency is identical in both builds.

## Test plan
- WIDTH=8, DIGITS=3, unsigned: start with bin=8'd255 -> busy for cycles 1–8, done in cycle 9, bcd=12'h255, overflow=0.
- WIDTH=8, DIGITS=3: bin=0, then bin=8'd99 with start held through DONE -> first result 12'h000, second result 12'h099 at 9 cycles after the DONE edge, no idle gap.
- WIDTH=8, DIGITS=2: bin=8'd100 -> bcd=8'h00, overflow=1. Then bin=8'd42 -> bcd=8'h42, overflow=0.
- Start bin=8'd17, pulse start again with bin=8'd200 in cycle 3 -> exactly one done, in cycle 9, with bcd=12'h017.
- Start bin=8'd123, assert rst in cycle 4 -> no done pulse. Cycle 5 onward: bcd=0, busy=0, state IDLE. A following start with bin=8'd7 gives 12'h007.
- BIN2BCD_SIGNED_EN, WIDTH=8, DIGITS=3: bin=8'h80 -> neg=1, bcd=12'h128. bin=8'hFF -> neg=1, bcd=12'h001. bin=8'd127 -> neg=0, bcd=12'h127.

Source files
------------

// File: rtl/bin2bcd_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_if
// Handshake and result bundle for the iterative binary-to-BCD converter.
//
// Parameters:
//   WIDTH   binary operand width
//   DIGITS  number of BCD digits in the result
//
// Signals:
//   start     request a conversion (driven by the master)
//   bin       operand, WIDTH bits (driven by the master)
//   busy      converter is shifting
//   done      one-cycle pulse when the result registers update
//   bcd       result, 4*DIGITS bits, least-significant digit in [3:0]
//   overflow  value did not fit in DIGITS digits
//   neg       sign of the converted operand (signed build only, else 0)
//
// Modports: master = requester (ALU side), slave = converter.
// ---------------------------------------------------------------------------
interface bin2bcd_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic                  neg;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow, neg
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow, neg
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Iterative binary-to-BCD converter (shift-and-add-3 / double dabble).
// One operand bit is consumed per clock, so a single row of DIGITS add-3
// cells is reused WIDTH times. A conversion takes WIDTH+1 cycles from the
// accepting edge to the done pulse; the result is held until the next
// conversion completes.
//
// Parameters:
//   WIDTH   operand width, 2..32
//   DIGITS  BCD output digits, 1..10
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   bin2bcd_if.slave: start/bin in; busy/done/bcd/overflow/neg out
//
// Optional feature macro: BIN2BCD_SIGNED_EN
//   defined   -> bin is two's complement; the magnitude is converted and
//                neg carries the captured sign.
//   undefined -> bin is unsigned, neg is tied low, no negation logic.
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst,
    bin2bcd_if.slave   bus
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  shift_reg;
    logic [BW-1:0]     scratch_reg;
    logic [CW-1:0]     cnt_reg;
    logic              acc_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [BW-1:0]     bcd_reg;
    logic              overflow_reg;

    // Operand as it enters the shifter.
    logic [WIDTH-1:0]  mag;

`ifdef BIN2BCD_SIGNED_EN
    logic              sign_in;
    logic              sign_reg;
    logic              neg_reg;

    // Two's complement magnitude; -2^(WIDTH-1) maps onto 2^(WIDTH-1),
    // which is still representable as an unsigned WIDTH-bit value.
    assign sign_in = bus.bin[WIDTH-1];
    assign mag     = sign_in ? ((~bus.bin) + WIDTH'(1)) : bus.bin;
    assign bus.neg = neg_reg;
`else
    assign mag     = bus.bin;
    assign bus.neg = 1'b0;
`endif

    // Add-3 correction row: any digit >= 5 gets +3 before the shift so the
    // doubling carries correctly into the next digit. 5+3..9+3 fit in 4 bits.
    logic [BW-1:0] adj;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                    ? (scratch_reg[gi*4 +: 4] + 4'd3)
                                    : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    // One left shift of {digits, operand}.
    logic [BW-1:0]     scratch_next;
    logic [WIDTH-1:0]  shift_next;
    logic              carry_out;

    assign scratch_next = {adj[BW-2:0], shift_reg[WIDTH-1]};
    assign shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
    assign carry_out    = adj[BW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            scratch_reg  <= '0;
            cnt_reg      <= '0;
            acc_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            bcd_reg      <= '0;
            overflow_reg <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_reg     <= 1'b0;
            neg_reg      <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        shift_reg   <= mag;
                        scratch_reg <= '0;
                        cnt_reg     <= CW'(WIDTH);
                        acc_reg     <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= CONV;
`ifdef BIN2BCD_SIGNED_EN
                        sign_reg    <= sign_in;
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end

                CONV: begin
                    scratch_reg <= scratch_next;
                    shift_reg   <= shift_next;
                    acc_reg     <= acc_reg | carry_out;
                    cnt_reg     <= cnt_reg - CW'(1);
                    // Last bit is being shifted in on this edge: publish
                    // the post-shift digits directly so DONE sees them.
                    if (cnt_reg == CW'(1)) begin
                        bcd_reg      <= scratch_next;
                        overflow_reg <= acc_reg | carry_out;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= DONE;
`ifdef BIN2BCD_SIGNED_EN
                        neg_reg      <= sign_reg;
`endif
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.bcd      = bcd_reg;
    assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bin2bcd_if #(.WIDTH(8), .DIGITS(3)) if3 ();
    bin2bcd_if #(.WIDTH(8), .DIGITS(2)) if2 ();

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
        logic        neg;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 2) ? if2.done : if3.done;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 2) ? if2.busy : if3.busy;
    endfunction

    function automatic logic get_ovf(input int sel);
        return (sel == 2) ? if2.overflow : if3.overflow;
    endfunction

    function automatic logic get_neg(input int sel);
        return (sel == 2) ? if2.neg : if3.neg;
    endfunction

    function automatic logic [11:0] get_bcd(input int sel);
        return (sel == 2) ? {4'h0, if2.bcd} : if3.bcd;
    endfunction

    task automatic set_start(input int sel, input logic s);
        if (sel == 2) if2.start = s;
        else          if3.start = s;
    endtask

    task automatic set_bin(input int sel, input logic [7:0] b);
        if (sel == 2) if2.bin = b;
        else          if3.bin = b;
    endtask

    // Reference: decimal digits of the (signed-build: magnitude of) operand.
    function automatic exp_t model(input int sel, input logic [7:0] b);
        exp_t e;
        int   val;
        int   nd;
        e  = '0;
        nd = (sel == 2) ? 2 : 3;
`ifdef BIN2BCD_SIGNED_EN
        e.neg = b[7];
        val   = b[7] ? (256 - int'(b)) : int'(b);
`else
        e.neg = 1'b0;
        val   = int'(b);
`endif
        e.ovf = (val >= ((nd == 2) ? 100 : 1000));
        for (int i = 0; i < 3; i++) begin
            if (i < nd) begin
                e.bcd[4*i +: 4] = 4'(val % 10);
                val = val / 10;
            end
        end
        return e;
    endfunction

    // Called at a negedge: present a request and record the expectation.
    task automatic drive_start(input int sel, input logic [7:0] b);
        set_start(sel, 1'b1);
        set_bin(sel, b);
        sb_q.push_back(model(sel, b));
        $display("tb: dut%0d start bin=0x%02h", sel, b);
    endtask

    // Follows one conversion from its accepting edge to the done pulse.
    // Returns at the negedge of the DONE cycle.
    task automatic wait_done(input int sel, input bit keep_start, input int pulse_cyc);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1 && !keep_start) set_start(sel, 1'b0);
            if (pulse_cyc != 0 && cyc == pulse_cyc) begin
                set_start(sel, 1'b1);
                set_bin(sel, 8'd200);
            end
            if (pulse_cyc != 0 && cyc == pulse_cyc + 1) set_start(sel, 1'b0);
            if (get_done(sel) === 1'b1) begin
                seen = 1'b1;
                e = sb_q.pop_front();
                check("latency", 32'(cyc), 32'd9);
                check("busy_at_done", 32'(get_busy(sel)), 32'd0);
                check("bcd", 32'(get_bcd(sel)), 32'(e.bcd));
                check("overflow", 32'(get_ovf(sel)), 32'(e.ovf));
                check("neg", 32'(get_neg(sel)), 32'(e.neg));
                $display("tb: dut%0d done cyc=%0d bcd=0x%03h ovf=%0b neg=%0b", sel, cyc,
                         get_bcd(sel), get_ovf(sel), get_neg(sel));
            end else if (cyc <= 8) begin
                check("busy", 32'(get_busy(sel)), 32'd1);
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (!seen && sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    initial begin
        bit extra_done;
        if3.start = 1'b0;
        if3.bin   = '0;
        if2.start = 1'b0;
        if2.bin   = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy3", 32'(if3.busy), 32'd0);
        check("rst_done3", 32'(if3.done), 32'd0);
        check("rst_bcd3",  32'(if3.bcd), 32'd0);
        check("rst_ovf3",  32'(if3.overflow), 32'd0);
        check("rst_neg3",  32'(if3.neg), 32'd0);
        check("rst_busy2", 32'(if2.busy), 32'd0);
        check("rst_bcd2",  32'(if2.bcd), 32'd0);
        check("rst_done2", 32'(if2.done), 32'd0);

        // Full-scale operand
        drive_start(3, 8'd255);
        wait_done(3, 1'b0, 0);
        @(negedge clk);

        // Back-to-back: start held through DONE, no idle gap
        drive_start(3, 8'd0);
        wait_done(3, 1'b1, 0);
        drive_start(3, 8'd99);
        wait_done(3, 1'b0, 0);
        @(negedge clk);
        check("b2b_done_drop", 32'(if3.done), 32'd0);

        // Two-digit converter: overflow then in-range
        drive_start(2, 8'd100);
        wait_done(2, 1'b0, 0);
        @(negedge clk);
        drive_start(2, 8'd42);
        wait_done(2, 1'b0, 0);
        @(negedge clk);
        drive_start(2, 8'd99);
        wait_done(2, 1'b0, 0);
        @(negedge clk);

        // start pulse during CONV is ignored; bin not re-sampled
        drive_start(3, 8'd17);
        wait_done(3, 1'b0, 3);
        extra_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if3.done === 1'b1) extra_done = 1'b1;
        end
        check("single_done", 32'(extra_done), 32'd0);
        check("bcd_held", 32'(if3.bcd), 32'(model(3, 8'd17).bcd));

        // Reset mid-conversion abandons it
        drive_start(3, 8'd123);
        @(posedge clk);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            if (cyc == 1) set_start(3, 1'b0);
            if (cyc == 4) rst = 1'b1;
        end
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(if3.busy), 32'd0);
        check("abort_bcd", 32'(if3.bcd), 32'd0);
        check("abort_done", 32'(if3.done), 32'd0);
        check("abort_bcd2", 32'(if2.bcd), 32'd0);
        extra_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if3.done === 1'b1) extra_done = 1'b1;
        end
        check("abort_no_done", 32'(extra_done), 32'd0);
        drive_start(3, 8'd7);
        wait_done(3, 1'b0, 0);
        @(negedge clk);

`ifdef BIN2BCD_SIGNED_EN
        drive_start(3, 8'h80);
        wait_done(3, 1'b0, 0);
        @(negedge clk);
        drive_start(3, 8'hFF);
        wait_done(3, 1'b0, 0);
        @(negedge clk);
        drive_start(3, 8'd127);
        wait_done(3, 1'b0, 0);
        @(negedge clk);
`endif

        // A few random operands on both converters
        for (int i = 0; i < 6; i++) begin
            int sel;
            sel = (i % 2 == 0) ? 3 : 2;
            drive_start(sel, 8'($urandom_range(0, 255)));
            wait_done(sel, 1'b0, 0);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
